// File: rtl/i2s_receiver.sv
// i2s_receiver: oversampled I2S slave receiver. The bit clock, word select and
// data are synchronised into clk48m, sclk rising edges are detected, and MSB-first
// words are assembled into per-channel sample registers.
//
// Ports
//   clk48m    : system clock (all state on its rising edge)
//   rst       : asynchronous active-high reset
//   sclk      : external I2S bit clock (asynchronous)
//   lrclk     : word select, 0 = left, 1 = right (asynchronous)
//   din       : serial data, MSB first, one bit after each lrclk change (asynchronous)
//   left      : last complete left sample
//   right     : last complete right sample
//   valid     : one-cycle pulse when a left/right pair has completed
//   frame_err : one-cycle pulse when a slot ended before WIDTH bits arrived
module i2s_receiver #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk48m,
    input  logic             rst,
    input  logic             sclk,
    input  logic             lrclk,
    input  logic             din,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right,
    output logic             valid,
    output logic             frame_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] lr_sync_q,   lr_sync_d;
    logic [SYNC_STAGES-1:0] din_sync_q,  din_sync_d;

    logic             sclk_prev_q, sclk_prev_d;
    logic             lr_prev_q,   lr_prev_d;
    logic             chan_q,      chan_d;
    logic             armed_q,     armed_d;
    logic             left_ok_q,   left_ok_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] shift_q,     shift_d;
    logic [WIDTH-1:0] left_q,      left_d;
    logic [WIDTH-1:0] right_q,     right_d;
    logic             valid_q,     valid_d;
    logic             ferr_q,      ferr_d;

    logic sclk_s;
    logic lr_s;
    logic din_s;
    logic sclk_edge;
    logic lr_change;
    logic word_done;

    // Synchronised views of the serial pins
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign lr_s   = lr_sync_q[SYNC_STAGES-1];
    assign din_s  = din_sync_q[SYNC_STAGES-1];

    // Synchroniser chains and sclk edge history
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0],   lrclk};
        din_sync_d  = {din_sync_q[SYNC_STAGES-2:0],  din};
        sclk_prev_d = sclk_s;
    end

    // Word assembly, channel tracking and output loading
    always_comb begin
        lr_prev_d = lr_prev_q;
        chan_d    = chan_q;
        armed_d   = armed_q;
        left_ok_d = left_ok_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        word_done = 1'b0;
        sclk_edge = sclk_s & ~sclk_prev_q;
        lr_change = 1'b0;

        if (sclk_edge) begin
            lr_change = (lr_s != lr_prev_q);
            lr_prev_d = lr_s;

            // The change edge still carries the previous word's LSB
            if (cnt_q < CNT_W'(WIDTH)) begin
                shift_d   = {shift_q[WIDTH-2:0], din_s};
                cnt_d     = cnt_q + CNT_W'(1);
                word_done = armed_q && (cnt_q == CNT_W'(WIDTH - 1));
            end

            if (word_done) begin
                if (!chan_q) begin
                    left_d    = shift_d;
                    left_ok_d = 1'b1;
                end else begin
                    right_d   = shift_d;
                    valid_d   = left_ok_q;
                    left_ok_d = 1'b0;
                end
            end

            // A slot that ends short is dropped; the pairing restarts
            if (lr_change) begin
                if (armed_q && (cnt_d < CNT_W'(WIDTH))) begin
                    ferr_d    = 1'b1;
                    left_ok_d = 1'b0;
                end
                cnt_d   = '0;
                chan_d  = lr_s;
                armed_d = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            lr_sync_q   <= '0;
            din_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            lr_prev_q   <= 1'b0;
            chan_q      <= 1'b0;
            armed_q     <= 1'b0;
            left_ok_q   <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            lr_sync_q   <= lr_sync_d;
            din_sync_q  <= din_sync_d;
            sclk_prev_q <= sclk_prev_d;
            lr_prev_q   <= lr_prev_d;
            chan_q      <= chan_d;
            armed_q     <= armed_d;
            left_ok_q   <= left_ok_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
        end
    end

    assign left      = left_q;
    assign right     = right_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: directed bench for i2s_receiver. Slots are described at word
// level (channel, slot length, data); a word-level model turns them into an
// ordered list of observable output events that a per-cycle monitor consumes.
module tb_i2s_receiver;

    localparam int unsigned W = 16;

    logic         clk48m = 1'b0;
    logic         rst    = 1'b1;
    logic         sclk   = 1'b0;
    logic         lrclk  = 1'b0;
    logic         din    = 1'b0;
    logic [W-1:0] left;
    logic [W-1:0] right;
    logic         valid;
    logic         frame_err;

    i2s_receiver #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk48m   (clk48m),
        .rst      (rst),
        .sclk     (sclk),
        .lrclk    (lrclk),
        .din      (din),
        .left     (left),
        .right    (right),
        .valid    (valid),
        .frame_err(frame_err)
    );

    always #5 clk48m = ~clk48m;

    // Event kinds: 0 left load, 1 right load, 2 frame error
    typedef struct {
        int          kind;
        bit          v;
        logic [15:0] l;
        logic [15:0] r;
    } ev_t;

    ev_t evq[$];
    bit  q_lr[$];
    bit  q_d[$];

    int n_chk   = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_ferr  = 0;
    int half    = 3;

    // Word-level model state
    bit          pend_bit;
    bit          m_prev_ch;
    bit          m_has_pend;
    bit          m_pend_armed;
    bit          m_pend_ch;
    int          m_pend_n;
    logic [31:0] m_pend_data;
    bit          m_left_ok;
    logic [15:0] m_cur_l;
    logic [15:0] m_cur_r;

    function automatic void push_ev(input int kind, input bit v, input logic [15:0] l,
                                    input logic [15:0] r);
        ev_t e;
        e.kind = kind; e.v = v; e.l = l; e.r = r;
        evq.push_back(e);
    endfunction

    function automatic void model_reset();
        m_prev_ch    = 1'b0;
        m_has_pend   = 1'b0;
        m_pend_armed = 1'b0;
        m_left_ok    = 1'b0;
        m_cur_l      = 16'h0;
        m_cur_r      = 16'h0;
    endfunction

    // Decide the fate of the slot that the current lrclk change closes
    function automatic void finish_slot();
        logic [15:0] word;
        if (m_pend_n >= 16) begin
            word = 16'(m_pend_data >> (m_pend_n - 16));
            if (!m_pend_ch) begin
                if (word != m_cur_l) push_ev(0, 1'b0, word, m_cur_r);
                m_cur_l   = word;
                m_left_ok = 1'b1;
            end else begin
                if (m_left_ok) push_ev(1, 1'b1, m_cur_l, word);
                else if (word != m_cur_r) push_ev(1, 1'b0, m_cur_l, word);
                m_cur_r   = word;
                m_left_ok = 1'b0;
            end
        end else begin
            push_ev(2, 1'b0, m_cur_l, m_cur_r);
            m_left_ok = 1'b0;
        end
    endfunction

    // Append one slot: n bit periods with lrclk = ch, data delayed by one bit
    function automatic void add_slot(input bit ch, input int n, input logic [31:0] data);
        q_lr.push_back(ch);
        q_d.push_back(pend_bit);
        for (int j = 1; j < n; j++) begin
            q_lr.push_back(ch);
            q_d.push_back(data[n-j]);
        end
        pend_bit = data[0];
        if (ch != m_prev_ch) begin
            if (m_has_pend && m_pend_armed) finish_slot();
            m_pend_armed = 1'b1;
        end else begin
            m_pend_armed = 1'b0;
        end
        m_has_pend  = 1'b1;
        m_pend_ch   = ch;
        m_pend_n    = n;
        m_pend_data = data;
        m_prev_ch   = ch;
    endfunction

    task automatic drive_n(input int n);
        for (int i = 0; i < n; i++) begin
            if (q_lr.size() == 0) break;
            @(negedge clk48m);
            sclk  = 1'b0;
            lrclk = q_lr.pop_front();
            din   = q_d.pop_front();
            repeat (half) @(negedge clk48m);
            sclk = 1'b1;
            repeat (half - 1) @(negedge clk48m);
        end
    endtask

    task automatic drive_keep(input int keep);
        drive_n(q_lr.size() - keep);
    endtask

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic settle();
        repeat (20) @(negedge clk48m);
        check_eq("events_drained", 32'(evq.size()), 32'd0);
    endtask

    task automatic take_ev(input int kind, input bit v, input logic [15:0] l,
                           input logic [15:0] r, input string name);
        ev_t e;
        bit  ok;
        n_chk++;
        if (evq.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event left=%h right=%h, required no event", name, l, r);
        end else begin
            e  = evq.pop_front();
            ok = (e.kind == kind) && (e.v == v);
            if (kind == 0) ok = ok && (l == e.l);
            if (kind == 1) ok = ok && (r == e.r) && (!v || (l == e.l));
            if (!ok) begin
                n_fail++;
                $display("FAIL %s: got kind=%0d valid=%b left=%h right=%h, required kind=%0d valid=%b left=%h right=%h",
                         name, kind, v, l, r, e.kind, e.v, e.l, e.r);
            end
        end
    endtask

    // Per-cycle monitor: every observable output change must match the next event
    initial begin
        logic [15:0] seen_l;
        logic [15:0] seen_r;
        seen_l = 16'h0;
        seen_r = 16'h0;
        forever begin
            @(negedge clk48m);
            if (rst) begin
                n_chk++;
                if (left !== 16'h0 || right !== 16'h0 || valid !== 1'b0 || frame_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_state: left=%h right=%h valid=%b frame_err=%b, required all zero",
                             left, right, valid, frame_err);
                end
                seen_l = 16'h0;
                seen_r = 16'h0;
            end else begin
                if (frame_err) begin
                    n_ferr++;
                    take_ev(2, 1'b0, left, right, "frame_err");
                end
                if (valid) begin
                    n_valid++;
                    take_ev(1, 1'b1, left, right, "valid_pair");
                end
                if (left !== seen_l) begin
                    take_ev(0, 1'b0, left, right, "left_load");
                    seen_l = left;
                end
                if (right !== seen_r) begin
                    if (!valid) take_ev(1, 1'b0, left, right, "right_load");
                    seen_r = right;
                end
            end
        end
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          v0;
        int          f0;
        logic [15:0] l_cur;
        logic [15:0] l_next;
        logic [15:0] r_rnd;

        pend_bit = 1'b0;
        model_reset();

        // Reset held with pins toggling
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk48m);
            sclk  = 1'($urandom);
            lrclk = 1'($urandom);
            din   = 1'($urandom);
        end
        @(negedge clk48m);
        sclk = 1'b0; lrclk = 1'b0; din = 1'b0;
        repeat (4) @(negedge clk48m);
        @(posedge clk48m);
        #2 rst = 1'b0;
        check_eq("reset_left", 32'(left), 32'h0);
        check_eq("reset_right", 32'(right), 32'h0);

        // 16-bit slots after a priming frame
        v0 = n_valid; f0 = n_ferr;
        add_slot(1'b0, 16, 32'h5555);
        add_slot(1'b1, 16, 32'h0F0F);
        add_slot(1'b0, 16, 32'h1234);
        add_slot(1'b1, 16, 32'hABCD);
        add_slot(1'b0, 32, 32'h8001FFFF);
        drive_keep(31);
        settle();
        check_eq("s16_left", 32'(left), 32'h1234);
        check_eq("s16_right", 32'(right), 32'hABCD);
        check_eq("s16_valid_count", 32'(n_valid - v0), 32'd1);
        check_eq("s16_ferr_count", 32'(n_ferr - f0), 32'd0);

        // 32-bit slots, padding bits all ones
        v0 = n_valid; f0 = n_ferr;
        add_slot(1'b1, 32, 32'h7FFFFFFF);
        add_slot(1'b0, 32, 32'h8001FFFF);
        add_slot(1'b1, 32, 32'h7FFFFFFF);
        add_slot(1'b0, 16, 32'h2468);
        drive_keep(15);
        settle();
        check_eq("s32_left", 32'(left), 32'h8001);
        check_eq("s32_right", 32'(right), 32'h7FFF);
        check_eq("s32_valid_count", 32'(n_valid - v0), 32'd2);
        check_eq("s32_ferr_count", 32'(n_ferr - f0), 32'd0);

        // Short left slot of 10 bits
        v0 = n_valid; f0 = n_ferr;
        add_slot(1'b1, 16, 32'h1357);
        add_slot(1'b0, 10, 32'h2AA);
        add_slot(1'b1, 16, 32'h0BAD);
        add_slot(1'b0, 16, 32'h4321);
        drive_keep(15);
        settle();
        check_eq("short_ferr_count", 32'(n_ferr - f0), 32'd1);
        check_eq("short_left_kept", 32'(left), 32'h2468);
        check_eq("short_right", 32'(right), 32'h0BAD);
        check_eq("short_valid_count", 32'(n_valid - v0), 32'd1);
        v0 = n_valid;
        add_slot(1'b1, 16, 32'h8765);
        add_slot(1'b0, 16, 32'h7777);
        drive_keep(15);
        settle();
        check_eq("recover_left", 32'(left), 32'h4321);
        check_eq("recover_right", 32'(right), 32'h8765);
        check_eq("recover_valid_count", 32'(n_valid - v0), 32'd1);

        // Reset during the right slot, released inside the following left slot
        add_slot(1'b1, 16, 32'h9999);
        drive_keep(9);
        @(posedge clk48m);
        #2 rst = 1'b1;
        check_eq("events_before_reset", 32'(evq.size()), 32'd0);
        evq.delete();
        model_reset();
        drive_n(9);
        add_slot(1'b0, 16, 32'hAAAA);
        drive_n(5);
        @(negedge clk48m);
        sclk = 1'b0;
        repeat (4) @(negedge clk48m);
        @(posedge clk48m);
        #2 rst = 1'b0;
        v0 = n_valid; f0 = n_ferr;
        l_next = 16'($urandom);
        add_slot(1'b1, 16, 32'h0101);
        add_slot(1'b0, 16, 32'hC3C3);
        add_slot(1'b1, 16, 32'h3C3C);
        add_slot(1'b0, 16, 32'(l_next));
        drive_keep(15);
        settle();
        check_eq("rst_mid_left", 32'(left), 32'hC3C3);
        check_eq("rst_mid_right", 32'(right), 32'h3C3C);
        check_eq("rst_mid_valid_count", 32'(n_valid - v0), 32'd1);
        check_eq("rst_mid_ferr_count", 32'(n_ferr - f0), 32'd0);

        // Maximum rate, 100 random frames
        half = 2;
        v0 = n_valid; f0 = n_ferr;
        r_rnd = 16'h0;
        l_cur = l_next;
        for (int i = 0; i < 100; i++) begin
            l_cur  = l_next;
            r_rnd  = 16'($urandom);
            l_next = 16'($urandom);
            add_slot(1'b1, 16, 32'(r_rnd));
            add_slot(1'b0, 16, 32'(l_next));
        end
        drive_keep(15);
        settle();
        check_eq("fast_valid_count", 32'(n_valid - v0), 32'd100);
        check_eq("fast_ferr_count", 32'(n_ferr - f0), 32'd0);
        check_eq("fast_last_left", 32'(left), 32'(l_cur));
        check_eq("fast_last_right", 32'(right), 32'(r_rnd));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
